// File: rtl/matvec_ctrl.sv
// rtl/matvec_ctrl.sv - control FSM for the NxN matrix-vector multiply datapath
//
// Sequences the upstream word stream into matrix/vector memory writes, walks
// the read addresses and accumulator controls for each row, and hands each
// finished row to the downstream consumer.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   input_valid      upstream word valid
//   input_ready      a word is accepted this cycle (IDLE, LOAD_M, LOAD_X)
//   new_matrix       on the first word of a problem: 1 = matrix words follow
//   output_valid     accumulator holds a finished row result
//   output_ready     downstream accepts the row result
//   wr_en_m, addr_m  matrix memory write enable / address (write or read)
//   wr_en_x, addr_x  vector memory write enable / address (write or read)
//   clear_acc        accumulator loads the product instead of adding it
//   en_acc           accumulator update enable
module matvec_ctrl #(
    parameter int N  = 8,
    parameter int AM = $clog2(N*N),
    parameter int AX = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic          new_matrix,
    output logic          output_valid,
    input  logic          output_ready,
    output logic          wr_en_m,
    output logic [AM-1:0] addr_m,
    output logic          wr_en_x,
    output logic [AX-1:0] addr_x,
    output logic          clear_acc,
    output logic          en_acc
);
    typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_X, COMPUTE, OUT} state_t;

    // k runs 0..N inside COMPUTE, so it needs one bit more than a column index
    localparam int            KW       = AX + 1;
    localparam logic [AM-1:0] M_LAST   = AM'(N*N - 1);
    localparam logic [AM-1:0] X_LAST   = AM'(N - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N);
    localparam logic [AX-1:0] COL_LAST = AX'(N - 1);

    state_t        state;
    logic [AM-1:0] count;
    logic [AX-1:0] row;
    logic [KW-1:0] k;
    logic          matrix_loaded;

    logic          hs;
    logic          take_matrix;
    logic [AX-1:0] k_rd;

    assign input_ready  = !reset && (state == IDLE || state == LOAD_M || state == LOAD_X);
    assign output_valid = !reset && (state == OUT);
    assign hs           = input_valid && input_ready;

    // Only meaningful in IDLE; elsewhere new_matrix may be X and is masked by state
    assign take_matrix  = new_matrix || !matrix_loaded;
    assign wr_en_m      = hs && (state == LOAD_M || (state == IDLE && take_matrix));
    assign wr_en_x      = hs && (state == LOAD_X || (state == IDLE && !take_matrix));

    // The final compute cycle and OUT park on the last column, keeping the
    // read addresses frozen while the result waits for the consumer.
    assign k_rd = (k >= K_LAST) ? COL_LAST : k[AX-1:0];

    always_comb begin
        addr_m    = '0;
        addr_x    = '0;
        en_acc    = 1'b0;
        clear_acc = 1'b0;
        if (!reset) begin
            if (state == COMPUTE || state == OUT) begin
                addr_m    = AM'(row) * AM'(N) + AM'(k_rd);
                addr_x    = k_rd;
                // Read data lags the address by one cycle, so the MAC runs in k=1..N
                en_acc    = (state == COMPUTE) && (k != '0);
                clear_acc = (state == COMPUTE) && (k == KW'(1));
            end else begin
                addr_m = count;
                addr_x = count[AX-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            row           <= '0;
            k             <= '0;
            matrix_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        count <= AM'(1);
                        state <= take_matrix ? LOAD_M : LOAD_X;
                    end
                end
                LOAD_M: begin
                    if (hs) begin
                        if (count == M_LAST) begin
                            count         <= '0;
                            matrix_loaded <= 1'b1;
                            state         <= LOAD_X;
                        end else begin
                            count <= count + AM'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (hs) begin
                        if (count == X_LAST) begin
                            count <= '0;
                            row   <= '0;
                            k     <= '0;
                            state <= COMPUTE;
                        end else begin
                            count <= count + AM'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (k == K_LAST) begin
                        state <= OUT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                OUT: begin
                    if (output_ready) begin
                        k <= '0;
                        if (row == COL_LAST) begin
                            state <= IDLE;
                        end else begin
                            row   <= row + AX'(1);
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_ctrl.sv
// tb/tb_matvec_ctrl.sv - scoreboard testbench for matvec_ctrl
`timescale 1ns/1ps
module tb_matvec_ctrl;
    localparam int N  = 8;
    localparam int AM = 6;
    localparam int AX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic          new_matrix = 1'b0;
    logic          output_valid;
    logic          output_ready = 1'b0;
    logic          wr_en_m;
    logic [AM-1:0] addr_m;
    logic          wr_en_x;
    logic [AX-1:0] addr_x;
    logic          clear_acc;
    logic          en_acc;

    matvec_ctrl #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .wr_en_m      (wr_en_m),
        .addr_m       (addr_m),
        .wr_en_x      (wr_en_x),
        .addr_x       (addr_x),
        .clear_acc    (clear_acc),
        .en_acc       (en_acc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Datapath stand-in: memories with 1-cycle read latency and an accumulator
    logic signed [13:0] din = '0;
    logic signed [13:0] mem_m [64];
    logic signed [13:0] mem_x [8];
    logic signed [13:0] rd_m = '0;
    logic signed [13:0] rd_x = '0;
    logic signed [27:0] prod;
    logic signed [27:0] acc = '0;

    int nwm = 0;
    int nwx = 0;
    int exp_mwords = 0;
    int outs_done = 0;
    bit hold_pending = 0;
    longint exp_q[$];

    logic signed [13:0] mat_a [64];
    logic signed [13:0] mat_b [64];
    logic signed [13:0] vec_1 [8];
    logic signed [13:0] vec_2 [8];
    logic signed [13:0] ref_mat [64];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory/accumulator model and write-address checks, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (en_acc) begin
            prod = rd_m * rd_x;
            acc  = clear_acc ? prod : acc + prod;
        end
        rd_m = mem_m[addr_m];
        rd_x = mem_x[addr_x];
        if (wr_en_m) begin
            check("wr_m_addr", longint'(addr_m), nwm);
            mem_m[addr_m] = din;
            nwm++;
        end
        if (wr_en_x) begin
            check("wr_x_addr", longint'(addr_x), nwx);
            check("m_words_before_x", nwm, exp_mwords);
            mem_x[addr_x] = din;
            nwx++;
        end
    end

    // Output monitor: pops the scoreboard on every presented result
    initial forever begin
        logic [AM-1:0] am;
        logic [AX-1:0] ax;
        @(negedge clk);
        if (output_valid) begin
            if (hold_pending && outs_done == 2) begin
                hold_pending = 0;
                am = addr_m;
                ax = addr_x;
                output_ready = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    check("hold_valid", output_valid, 1);
                    check("hold_en_acc", en_acc, 0);
                    check("hold_clear_acc", clear_acc, 0);
                    check("hold_addr_m", longint'(addr_m), longint'(am));
                    check("hold_addr_x", longint'(addr_x), longint'(ax));
                end
            end
            check("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check($sformatf("out_row%0d", outs_done), acc, exp_q.pop_front());
            output_ready = 1'b1;
            @(posedge clk);
            #1;
            output_ready = 1'b0;
            outs_done++;
        end
    end

    task automatic send_word(input logic signed [13:0] d, input logic nm, input bit first);
        int t;
        while ($urandom_range(0, 3) == 0) begin
            input_valid = 1'b0;
            new_matrix  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        input_valid = 1'b1;
        din         = d;
        new_matrix  = first ? nm : 1'($urandom);
        t = 0;
        forever begin
            @(negedge clk);
            if (input_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 100) begin
                check("input_ready_wait", input_ready, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        input_valid = 1'b0;
        new_matrix  = 1'($urandom);
    endtask

    task automatic run_problem(input bit use_b, input bit use_v2, input logic nm_first, input bit load_m);
        longint s;
        nwm = 0;
        nwx = 0;
        outs_done = 0;
        exp_mwords = load_m ? 64 : 0;
        if (load_m)
            for (int i = 0; i < 64; i++) ref_mat[i] = use_b ? mat_b[i] : mat_a[i];
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++)
                s += ref_mat[i*N+j] * (use_v2 ? vec_2[j] : vec_1[j]);
            exp_q.push_back(s);
        end
        if (load_m)
            for (int i = 0; i < 64; i++) send_word(ref_mat[i], nm_first, i == 0);
        for (int j = 0; j < N; j++)
            send_word(use_v2 ? vec_2[j] : vec_1[j], nm_first, !load_m && j == 0);
    endtask

    task automatic wait_outs(input int n, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (outs_done < n && t < 5000);
        check(name, outs_done >= n, 1);
    endtask

    initial begin
        int n;
        int seen;
        for (int i = 0; i < N; i++) begin
            vec_1[i] = 14'(i + 1);
            vec_2[i] = 14'sd1;
            for (int j = 0; j < N; j++) begin
                mat_a[i*N+j] = 14'(i + j);
                mat_b[i*N+j] = 14'(i - j);
            end
        end

        // Reset with input_valid high: nothing may be accepted or written
        reset = 1'b1;
        input_valid = 1'b1;
        new_matrix = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_input_ready", input_ready, 0);
        check("rst_output_valid", output_valid, 0);
        check("rst_en_acc", en_acc, 0);
        check("rst_clear_acc", clear_acc, 0);
        check("rst_wr_en_m", wr_en_m, 0);
        check("rst_wr_en_x", wr_en_x, 0);
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_input_ready", input_ready, 1);
        check("idle_output_valid", output_valid, 0);
        @(posedge clk);
        #1;

        // Problem 1: matrix A (i+j), vector j+1; row 2 stalled; row 3 window traced
        hold_pending = 1;
        run_problem(0, 0, 1'b1, 1);
        @(negedge clk);
        check("ready_low_after_last", input_ready, 0);
        n = 0;
        while (!output_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", n, 9);
        wait_outs(3, "reach_row3");
        for (int c = 0; c <= N; c++) begin
            if (c > 0) @(negedge clk);
            if (c < N) begin
                check($sformatf("r3_addr_m_c%0d", c), longint'(addr_m), 24 + c);
                check($sformatf("r3_addr_x_c%0d", c), longint'(addr_x), c);
            end
            check($sformatf("r3_en_acc_c%0d", c), en_acc, c >= 1);
            check($sformatf("r3_clear_acc_c%0d", c), clear_acc, c == 1);
        end
        @(negedge clk);
        check("r3_valid", output_valid, 1);
        wait_outs(8, "p1_outputs");
        check("p1_m_writes", nwm, 64);
        check("p1_x_writes", nwx, 8);
        check("p1_idle_ready", input_ready, 1);
        check("p1_idle_valid", output_valid, 0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (output_valid) seen++;
        end
        check("p1_no_valid_after", seen, 0);
        @(posedge clk);
        #1;

        // Problem 2: reuse stored matrix A with an all-ones vector
        run_problem(0, 1, 1'b0, 0);
        wait_outs(8, "p2_outputs");
        check("p2_m_writes", nwm, 0);
        check("p2_x_writes", nwx, 8);
        @(posedge clk);
        #1;

        // Problem 3: fresh reset, new_matrix=0 must still load a matrix (B = i-j)
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_problem(1, 0, 1'b0, 1);
        wait_outs(4, "reach_row4");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_output_valid", output_valid, 0);
        check("midrst_en_acc", en_acc, 0);
        check("midrst_input_ready", input_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("postrst_input_ready", input_ready, 1);
        check("postrst_output_valid", output_valid, 0);
        @(posedge clk);
        #1;

        // Problem 4: after a mid-compute reset the matrix must be reloaded
        run_problem(0, 0, 1'b0, 1);
        wait_outs(8, "p4_outputs");
        check("p4_m_writes", nwm, 64);
        check("p4_x_writes", nwx, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
